// File: rtl/of_stage_pipe.sv
// of_stage_pipe: operand-fetch stage with OF/EX latch, handshake, flush, stall counter; optional WB forwarding via OF_WB_FWD_EN
module of_stage_pipe #(
  parameter int PC_W        = 10,
  parameter int DATA_W      = 32,
  parameter int RADDR_W     = 4,
  parameter int RA_IDX      = 15,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PC_W-1:0]        in_pc,
  input  logic [DATA_W-1:0]      in_ir,
  input  logic                   is_store,
  input  logic                   is_return,
  input  logic                   is_immediate,
  input  logic                   flush,
`ifdef OF_WB_FWD_EN
  input  logic                   wb_we,
  input  logic [RADDR_W-1:0]     wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
`endif
  output logic [RADDR_W-1:0]     rf_addr1,
  output logic [RADDR_W-1:0]     rf_addr2,
  input  logic [DATA_W-1:0]      rf_data1,
  input  logic [DATA_W-1:0]      rf_data2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
  output logic [DATA_W-1:0]      out_ir,
  output logic [DATA_W-1:0]      out_branch_target,
  output logic [DATA_W-1:0]      out_op_a,
  output logic [DATA_W-1:0]      out_op_b,
  output logic [DATA_W-1:0]      out_op_2,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  logic [15:0]            imm;
  logic [1:0]             mod;
  logic [26:0]            off;
  logic [DATA_W-1:0]      d1, d2, imm_d, tgt_d, op2_d;
  logic                   valid_q, valid_d, cap;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]        pc_q;
  logic [DATA_W-1:0]      ir_q, tgt_q, a_q, b_q, op2_q;
  assign imm      = in_ir[15:0];
  assign mod      = in_ir[17:16];
  assign off      = in_ir[26:0];
  assign rf_addr1 = is_return ? RADDR_W'(RA_IDX) : in_ir[21:18];
  assign rf_addr2 = is_store ? in_ir[25:22] : in_ir[17:14];
`ifdef OF_WB_FWD_EN
  assign d1 = (wb_we && wb_addr == rf_addr1) ? wb_data : rf_data1;
  assign d2 = (wb_we && wb_addr == rf_addr2) ? wb_data : rf_data2;
`else
  assign d1 = rf_data1;
  assign d2 = rf_data2;
`endif
  always_comb begin
    imm_d   = mod == 2'b01 ? {{(DATA_W-16){1'b0}}, imm} :
              mod == 2'b10 ? {imm, {(DATA_W-16){1'b0}}} : {{(DATA_W-16){imm[15]}}, imm};
    tgt_d   = {{(DATA_W-PC_W){1'b0}}, in_pc} + {{(DATA_W-29){off[26]}}, off, 2'b00};
    op2_d   = is_immediate ? imm_d : d2;
    in_ready = !valid_q || out_ready;
    cap     = in_valid && in_ready && !flush;
    valid_d = flush ? 1'b0 : in_ready ? cap : valid_q;
    // stall counting is suppressed in a flush cycle
    cnt_d   = (valid_q && !out_ready && !flush && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      cnt_q   <= '0;
      pc_q    <= '0;
      ir_q    <= '0;
      tgt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op2_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      if (cap) begin
        pc_q  <= in_pc;
        ir_q  <= in_ir;
        tgt_q <= tgt_d;
        a_q   <= d1;
        b_q   <= d2;
        op2_q <= op2_d;
      end
    end
  end
  assign out_valid         = valid_q;
  assign stall_cnt         = cnt_q;
  assign out_pc            = pc_q;
  assign out_ir            = ir_q;
  assign out_branch_target = tgt_q;
  assign out_op_a          = a_q;
  assign out_op_b          = b_q;
  assign out_op_2          = op2_q;
endmodule

// File: tb/tb_of_stage_pipe.sv
// tb_of_stage_pipe: directed and random checks of of_stage_pipe against an arithmetic reference model
module tb_of_stage_pipe;
  localparam int CW = 4;
  logic clk = 0, reset = 1;
  logic in_valid = 0, in_ready, is_store = 0, is_return = 0, is_immediate = 0, flush = 0;
  logic [9:0] in_pc = 0, out_pc;
  logic [31:0] in_ir = 0, rf_data1, rf_data2, out_ir, out_branch_target, out_op_a, out_op_b, out_op_2;
  logic [3:0] rf_addr1, rf_addr2;
  logic out_valid, out_ready = 1;
  logic [CW-1:0] stall_cnt;
  logic [31:0] rf [16];
`ifdef OF_WB_FWD_EN
  logic wb_we = 0;
  logic [3:0] wb_addr = 0;
  logic [31:0] wb_data = 0;
`endif
  int total = 0, bad = 0;
  logic ev = 0;
  int ec = 0;
  logic [31:0] e_pc = 0, e_ir = 0, e_tgt = 0, e_a = 0, e_b = 0, e_2 = 0;
  always #5 clk = ~clk;
  assign rf_data1 = rf[rf_addr1];
  assign rf_data2 = rf[rf_addr2];
  of_stage_pipe #(.STALL_CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_ir(in_ir),
    .is_store(is_store), .is_return(is_return), .is_immediate(is_immediate), .flush(flush),
`ifdef OF_WB_FWD_EN
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
`endif
    .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ir(out_ir),
    .out_branch_target(out_branch_target), .out_op_a(out_op_a), .out_op_b(out_op_b),
    .out_op_2(out_op_2), .stall_cnt(stall_cnt));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] imm_of(input logic [31:0] ir);
    int unsigned i = ir & 32'hFFFF;
    int unsigned m = (ir >> 16) & 3;
    if (m == 1) return i;
    if (m == 2) return i * 65536;
    return i >= 32768 ? i + 32'hFFFF0000 : i;
  endfunction
  function automatic logic [31:0] tgt_of(input logic [31:0] pc, input logic [31:0] ir);
    longint off = longint'(ir & 32'h07FFFFFF);
    if (off >= 64'sd67108864) off -= 64'sd134217728;
    return 32'(longint'(pc) + off * 4);
  endfunction
  function automatic logic [31:0] rd_port(input int a);
`ifdef OF_WB_FWD_EN
    if (wb_we && int'(wb_addr) == a) return wb_data;
`endif
    return rf[a];
  endfunction
  task automatic chk_out();
    chk("out_valid", out_valid, ev);
    chk("stall_cnt", stall_cnt, ec);
    chk("out_pc", out_pc, e_pc);
    chk("out_ir", out_ir, e_ir);
    chk("out_tgt", out_branch_target, e_tgt);
    chk("out_op_a", out_op_a, e_a);
    chk("out_op_b", out_op_b, e_b);
    chk("out_op_2", out_op_2, e_2);
  endtask
  task automatic step();
    int a1, a2;
    logic rdy;
    #2;
    a1 = is_return ? 15 : int'((in_ir >> 18) & 15);
    a2 = is_store ? int'((in_ir >> 22) & 15) : int'((in_ir >> 14) & 15);
    rdy = !ev || out_ready;
    chk("in_ready", in_ready, rdy);
    chk("rf_addr1", rf_addr1, a1);
    chk("rf_addr2", rf_addr2, a2);
    if (flush) ev = 0;
    else if (rdy) begin
      ev = in_valid;
      if (in_valid) begin
        e_pc = in_pc; e_ir = in_ir; e_tgt = tgt_of(in_pc, in_ir);
        e_a = rd_port(a1); e_b = rd_port(a2);
        e_2 = is_immediate ? imm_of(in_ir) : rd_port(a2);
      end
    end else if (ec < (1 << CW) - 1) ec++;
    @(posedge clk); #1;
    chk_out();
  endtask
  task automatic clear_model();
    ev = 0; ec = 0; e_pc = 0; e_ir = 0; e_tgt = 0; e_a = 0; e_b = 0; e_2 = 0;
  endtask
  initial begin
    for (int i = 0; i < 16; i++) rf[i] = $urandom;
    repeat (2) @(posedge clk);
    #1 chk_out();
    reset = 0;
    // ADD with immediate, mod=11 sign-extends
    in_valid = 1; in_pc = 5; in_ir = 32'h0C4BFFFF; is_immediate = 1;
    step();
    chk("add_op2", out_op_2, 32'hFFFFFFFF);
    chk("add_pc", out_pc, 5);
    // store/return address muxing
    in_ir = 32'd3 << 22; is_store = 1; is_return = 1; is_immediate = 0;
    #1 chk("st_addr2", rf_addr2, 3);
    chk("ret_addr1", rf_addr1, 15);
    step();
    // branch wrap-around
    is_store = 0; is_return = 0; in_pc = 0; in_ir = 32'h07FFFFFF;
    step();
    chk("br_wrap", out_branch_target, 32'hFFFFFFFC);
    // back-pressure for 4 cycles
    out_ready = 0; in_ir = 32'h12345678; in_pc = 10'h155;
    repeat (4) step();
    chk("bp_cnt", stall_cnt, 4);
    chk("bp_ready", in_ready, 0);
    out_ready = 1;
    step();
    chk("bp_cap", out_pc, 10'h155);
    // flush drops incoming instruction
    in_ir = 32'hDEADBEEF; flush = 1;
`ifdef OF_WB_FWD_EN
    wb_we = 1; wb_addr = in_ir[21:18]; wb_data = 32'hA5A5A5A5;
`endif
    step();
    chk("flush_valid", out_valid, 0);
    flush = 0;
`ifdef OF_WB_FWD_EN
    step();
    chk("fwd_op_a", out_op_a, 32'hA5A5A5A5);
    wb_we = 0;
`endif
    // saturation
    out_ready = 0;
    repeat (20) step();
    chk("sat_cnt", stall_cnt, (1 << CW) - 1);
    // reset mid-stall
    #2 reset = 1;
    #1 clear_model();
    chk_out();
    @(posedge clk); #1 chk_out();
    reset = 0; out_ready = 1;
    for (int n = 0; n < 400; n++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 9) == 0;
      in_pc = 10'($urandom); in_ir = $urandom;
      is_store = 1'($urandom); is_return = 1'($urandom); is_immediate = 1'($urandom);
`ifdef OF_WB_FWD_EN
      wb_we = 1'($urandom); wb_addr = 4'($urandom); wb_data = $urandom;
`endif
      if (n % 50 == 0) for (int i = 0; i < 16; i++) rf[i] = $urandom;
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
